// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: N-channel arbiter and byte-serial engine for the 8-bit
// unified RAM/IO bus. One channel is granted per IDLE cycle. Its 1/2/4-byte
// access is then run one byte per cycle on mem_a/mem_din/mem_dout/mem_wr.
// The access finishes with a one-cycle done_o pulse on the granted channel.
module mem_arbiter_nch #(
  parameter int N_CH          = 2,
  parameter int PRIORITY_MODE = 0,
  parameter int ADDR_W        = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [N_CH-1:0]      req_i,
  input  logic [N_CH-1:0]      we_i,
  input  logic [N_CH*32-1:0]   addr_i,
  input  logic [N_CH*32-1:0]   wdata_i,
  input  logic [N_CH*2-1:0]    len_i,
  input  logic [N_CH-1:0]      flush_i,
  output logic [N_CH-1:0]      done_o,
  output logic [31:0]          rdata_o,
  output logic                 busy_o,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [ADDR_W-1:0]    mem_a,
  output logic                 mem_wr,
  input  logic                 io_buffer_full
);

  localparam int              CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W:0]   N_CH_V = (CH_W + 1)'(N_CH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_WAIT_IO,
    S_DONE
  } state_t;

  state_t          r_state, w_next_state;
  logic [CH_W-1:0] r_ch, r_rr;
  logic            r_we;
  logic            r_cap;      // mem_din this cycle holds byte r_cnt-1
  logic [31:0]     r_addr, r_wdata, r_rdata;
  logic [2:0]      r_nbytes, r_cnt;

  logic [31:0]     w_addr_arr  [N_CH];
  logic [31:0]     w_wdata_arr [N_CH];
  logic [1:0]      w_len_arr   [N_CH];
  logic [N_CH-1:0] w_cand, w_pick;
  logic            w_grant_valid;
  logic [CH_W-1:0] w_off, w_grant_ch, w_next_rr;
  logic [CH_W:0]   w_sum, w_inc;
  logic [2:0]      w_nbytes;
  logic            w_flush_cur, w_io_stall, w_last_wr;
  logic [31:0]     w_byte_addr;

  // Unpack the flattened per-channel request fields.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_addr_arr[i]  = addr_i[32*i +: 32];
      w_wdata_arr[i] = wdata_i[32*i +: 32];
      w_len_arr[i]   = len_i[2*i +: 2];
    end
  end

  // Winner selection: lowest index, or first requester at/after the rr pointer.
  // NOTE: every variable gets a default before any conditional assignment, so
  // no path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_cand        = req_i & ~flush_i;
    w_pick        = (PRIORITY_MODE == 1) ? N_CH'({w_cand, w_cand} >> r_rr) : w_cand;
    w_grant_valid = |w_pick;
    w_off         = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_pick[i]) w_off = CH_W'(i);
    end
    w_sum = {1'b0, w_off};
    if (PRIORITY_MODE == 1) w_sum = w_sum + {1'b0, r_rr};
    if (w_sum >= N_CH_V) w_sum = w_sum - N_CH_V;
    w_grant_ch = w_sum[CH_W-1:0];
    w_inc      = {1'b0, w_grant_ch} + (CH_W + 1)'(1);
    if (w_inc >= N_CH_V) w_inc = '0;
    w_next_rr = w_inc[CH_W-1:0];
    unique case (w_len_arr[w_grant_ch])
      2'd0:    w_nbytes = 3'd1;
      2'd1:    w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;  // 2 is illegal and runs as a 4-byte access
    endcase
  end

  // Status of the in-flight access used by both the FSM and the bus drivers.
  always_comb begin
    w_flush_cur = flush_i[r_ch] & ~r_we;  // stores always complete
    w_io_stall  = (r_addr[17:16] == 2'b11) & io_buffer_full;
    w_last_wr   = (r_cnt == r_nbytes - 3'd1);
    w_byte_addr = r_addr + {29'd0, r_cnt};  // wraps modulo 2^32
  end

  // Next-state logic; a low rdy_in freezes the FSM.
  always_comb begin
    w_next_state = r_state;
    if (rdy_in) begin
      unique case (r_state)
        S_IDLE:    if (w_grant_valid) w_next_state = we_i[w_grant_ch] ? S_WRITE : S_READ;
        S_READ:    if (w_flush_cur) w_next_state = S_IDLE;
                   else if (r_cnt == r_nbytes) w_next_state = S_DONE;
        S_WRITE:   if (w_io_stall) w_next_state = S_WAIT_IO;
                   else if (w_last_wr) w_next_state = S_DONE;
        S_WAIT_IO: if (!io_buffer_full) w_next_state = S_WRITE;
        S_DONE:    w_next_state = S_IDLE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the result does not depend on process order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Access datapath: latch the grant, step the byte counter, capture read bytes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_ch     <= '0;
      r_rr     <= '0;
      r_we     <= 1'b0;
      r_cap    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_nbytes <= '0;
      r_cnt    <= '0;
    end else if (rdy_in) begin
      case (r_state)
        S_IDLE: if (w_grant_valid) begin
          r_ch     <= w_grant_ch;
          r_we     <= we_i[w_grant_ch];
          r_addr   <= w_addr_arr[w_grant_ch];
          r_wdata  <= w_wdata_arr[w_grant_ch];
          r_nbytes <= w_nbytes;
          r_cnt    <= '0;
          r_cap    <= 1'b0;
          r_rdata  <= '0;
          if (PRIORITY_MODE == 1) r_rr <= w_next_rr;
        end
        S_READ: begin
          if (!w_flush_cur) begin
            for (int b = 0; b < 4; b++) begin
              if (r_cap && r_cnt == 3'(b + 1)) r_rdata[8*b +: 8] <= mem_din;
            end
          end
          if (!w_flush_cur && r_cnt != r_nbytes) begin
            r_cnt <= r_cnt + 3'd1;
            r_cap <= 1'b1;
          end else begin
            r_cap <= 1'b0;
          end
        end
        S_WRITE: if (!w_io_stall && !w_last_wr) r_cnt <= r_cnt + 3'd1;
        default: ;
      endcase
    end else if (r_state == S_READ && r_cap) begin
      // The byte due this cycle is lost; step back so its address is re-driven.
      r_cnt <= r_cnt - 3'd1;
      r_cap <= 1'b0;
    end
  end

  // Bus and completion outputs, decoded from the registered access state.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    done_o   = '0;
    unique case (r_state)
      S_READ:  if (rdy_in && r_cnt != r_nbytes) mem_a = ADDR_W'(w_byte_addr);
      S_WRITE, S_WAIT_IO: begin
        mem_a    = ADDR_W'(w_byte_addr);
        mem_dout = 8'(r_wdata >> {r_cnt, 3'b000});
        mem_wr   = rdy_in && (r_state == S_WRITE) && !w_io_stall;
      end
      S_DONE:  if (rdy_in && !w_flush_cur) done_o = N_CH'(1) << r_ch;
      default: ;
    endcase
  end

  assign busy_o  = (r_state != S_IDLE);
  assign rdata_o = r_rdata;

endmodule
